// File: rtl/bitcounter_pkg.sv
// Shared types and constants for the bitcounter_down countdown counter.
// The optional auto-reload build is selected with BITCOUNTER_DOWN_AUTORELOAD_EN.
package bitcounter_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Width needed to count 0 .. div-1; never narrower than one bit.
  function automatic int tick_cnt_w(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/bitcounter_down_tick_gen.sv
// Free-running clock divider: emits a one-cycle tick enable every TICK_DIV
// advancing cycles; clr restarts the count, hold freezes it.
module tick_gen
  import bitcounter_pkg::*;
#(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int TW = tick_cnt_w(TICK_DIV);
  localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] r_cnt;
  logic          w_wrap;

  // Tick is combinational off the count so the decrement lands on the wrap edge.
  assign w_wrap = !clr && !hold && (r_cnt == LAST);
  assign tick   = w_wrap;

  // Divider count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= {TW{1'b0}};
    end else if (clr) begin
      r_cnt <= {TW{1'b0}};
    end else if (hold) begin
      r_cnt <= r_cnt;
    end else if (w_wrap) begin
      r_cnt <= {TW{1'b0}};
    end else begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/bitcounter_down.sv
// Loadable 4-bit countdown counter with pause/stop and a one-cycle done pulse.
// Define BITCOUNTER_DOWN_AUTORELOAD_EN to reload from the reload register instead of stopping at 0.
module bitcounter_down
  import bitcounter_pkg::*;
#(
  parameter int TICK_DIV = 25000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic [CNT_W-1:0] counter,
  output logic             busy,
  output logic             done
);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_reload, w_reload_nxt;
  logic             r_busy, r_done, w_done_nxt;
  logic             w_idle_like, w_run_like, w_run_en, w_clr, w_tick;

  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_run_like  = (r_state == ST_RUN)  || (r_state == ST_PAUSE);
  // A cycle with stop or pause neither advances the divider nor takes a tick.
  assign w_run_en    = w_run_like && !stop && !pause;
  assign w_clr       = w_idle_like && !load && start && (r_cnt != {CNT_W{1'b0}});

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clr  (w_clr),
    .hold (!w_run_en),
    .tick (w_tick)
  );

  // Next-state, next-count and done decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_reload_nxt = r_reload;
    w_done_nxt   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (load) begin
          w_cnt_nxt    = load_val;
          w_reload_nxt = load_val;
          w_state_nxt  = ST_IDLE;
        end else if (start) begin
          if (r_cnt != {CNT_W{1'b0}}) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_RUN, ST_PAUSE: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (pause) begin
          w_state_nxt = ST_PAUSE;
        end else begin
          w_state_nxt = ST_RUN;
          if (w_tick) begin
            if (r_cnt == CNT_W'(1)) begin
              w_cnt_nxt  = {CNT_W{1'b0}};
              w_done_nxt = 1'b1;
`ifdef BITCOUNTER_DOWN_AUTORELOAD_EN
              w_state_nxt = ST_RUN;
`else
              w_state_nxt = ST_DONE;
`endif
            end else if (r_cnt != {CNT_W{1'b0}}) begin
              w_cnt_nxt = r_cnt - CNT_W'(1);
            end else begin
`ifdef BITCOUNTER_DOWN_AUTORELOAD_EN
              w_cnt_nxt  = r_reload;
              w_done_nxt = (r_reload == {CNT_W{1'b0}});
`else
              w_cnt_nxt  = r_cnt;
`endif
            end
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, count, reload and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= {CNT_W{1'b0}};
      r_reload <= {CNT_W{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_reload <= w_reload_nxt;
      r_busy   <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_PAUSE);
      r_done   <= w_done_nxt;
    end
  end

  assign counter = r_cnt;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_bitcounter_down.sv
// Self-checking bench for bitcounter_down: vector table, hand-written corner
// sequences and randomized stimulus against a tick-arithmetic reference model.
module tb_bitcounter_down;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset, load, start, pause, stop;
  logic [3:0] load_val;
  logic [3:0] counter;
  logic       busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       ld;
    logic [3:0] lv;
    logic       st;
    logic       pa;
    logic       sp;
    logic [3:0] e_cnt;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t tbl[$];

  // Reference model state: count, reload value, busy flag, RUN cycles since start.
  int m_cnt, m_rel, m_elapsed;
  bit m_active, m_done;

  bitcounter_down #(.TICK_DIV(DIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .load_val(load_val),
    .start   (start),
    .pause   (pause),
    .stop    (stop),
    .counter (counter),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic ld, input logic [3:0] lv, input logic st,
                      input logic pa, input logic sp);
    load = ld; load_val = lv; start = st; pause = pa; stop = sp;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic ld, input logic [3:0] lv, input logic st,
                              input logic pa, input logic sp, input logic [3:0] ec,
                              input logic eb, input logic ed);
    vec_t v;
    v.ld = ld; v.lv = lv; v.st = st; v.pa = pa; v.sp = sp;
    v.e_cnt = ec; v.e_busy = eb; v.e_done = ed;
    tbl.push_back(v);
  endfunction

  function automatic void model_reset();
    m_cnt = 0; m_rel = 0; m_elapsed = 0; m_active = 1'b0; m_done = 1'b0;
  endfunction

  // One clock of the specified behaviour: a decrement every DIV-th unpaused RUN cycle.
  function automatic void model_step(input bit ld, input int lv, input bit st,
                                     input bit pa, input bit sp);
    m_done = 1'b0;
    if (!m_active) begin
      if (ld) begin
        m_cnt = lv; m_rel = lv;
      end else if (st) begin
        if (m_cnt != 0) begin
          m_active = 1'b1; m_elapsed = 0;
        end else begin
          m_done = 1'b1;
        end
      end
    end else if (sp) begin
      m_active = 1'b0;
    end else if (!pa) begin
      m_elapsed++;
      if (m_elapsed % DIV == 0) begin
        if (m_cnt == 0) begin
          m_cnt = m_rel; m_done = (m_rel == 0);
        end else begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin
            m_done = 1'b1;
`ifndef BITCOUNTER_DOWN_AUTORELOAD_EN
            m_active = 1'b0;
`endif
          end
        end
      end
    end
  endfunction

  initial begin
    int exp_cnt;
    bit exp_busy, exp_done;
    bit r_ld, r_st, r_pa, r_sp;
    int r_lv;

    reset = 1'b0; load = 1'b0; load_val = 4'd0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cnt", int'(counter), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    reset = 1'b1;

    // load+start together, load ignored in RUN, 10-cycle pause, stop, zero start
    add(1, 5, 1, 0, 0, 5, 0, 0);
    add(0, 0, 0, 0, 0, 5, 0, 0);
    add(0, 0, 1, 0, 0, 5, 1, 0);
    add(1, 9, 0, 0, 0, 5, 1, 0);
    add(0, 0, 0, 0, 0, 5, 1, 0);
    add(0, 0, 0, 0, 0, 5, 1, 0);
    add(0, 0, 0, 0, 0, 4, 1, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 0, 1, 0, 4, 1, 0);
    add(0, 0, 0, 0, 0, 4, 1, 0);
    add(0, 0, 0, 0, 0, 4, 1, 0);
    add(0, 0, 0, 0, 0, 4, 1, 0);
    add(0, 0, 0, 0, 0, 3, 1, 0);
    add(0, 0, 0, 0, 1, 3, 0, 0);
    add(0, 0, 0, 0, 0, 3, 0, 0);
    add(0, 0, 1, 0, 0, 3, 1, 0);
    add(0, 0, 0, 0, 1, 3, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].pa, tbl[i].sp);
      chk($sformatf("vec%0d_cnt", i), int'(counter), int'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
      chk($sformatf("vec%0d_done", i), int'(done), int'(tbl[i].e_done));
    end

    // Count 3 -> 0: decrements at 4, 8, 12 cycles after the start edge
    step(1, 3, 0, 0, 0);
    chk("cnt3_load", int'(counter), 3);
    step(0, 0, 1, 0, 0);
    chk("cnt3_busy_rise", int'(busy), 1);
    for (int k = 1; k <= 16; k++) begin
      step(0, 0, 0, 0, 0);
      exp_cnt  = (k < 12) ? 3 - k / 4 : 0;
      exp_done = (k == 12);
`ifdef BITCOUNTER_DOWN_AUTORELOAD_EN
      exp_busy = 1'b1;
      if (k == 16) exp_cnt = 3;
`else
      exp_busy = (k < 12);
`endif
      chk($sformatf("cnt3_k%0d_cnt", k), int'(counter), exp_cnt);
      chk($sformatf("cnt3_k%0d_busy", k), int'(busy), int'(exp_busy));
      chk($sformatf("cnt3_k%0d_done", k), int'(done), int'(exp_done));
    end
    step(0, 0, 0, 0, 1);
    chk("cnt3_stop_busy", int'(busy), 0);

    // Asynchronous reset between clock edges mid-RUN
    step(1, 7, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0);
    chk("arst_pre_busy", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_cnt", int'(counter), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    #2 reset = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("arst_after_cnt", int'(counter), 0);
    chk("arst_after_busy", int'(busy), 0);

    // Randomized run against the reference model
    reset = 1'b0;
    model_reset();
    step(0, 0, 0, 0, 0);
    reset = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      r_ld = ($urandom_range(0, 7) == 0);
      r_lv = $urandom_range(0, 15);
      r_st = ($urandom_range(0, 5) == 0);
      r_pa = ($urandom_range(0, 4) == 0);
      r_sp = ($urandom_range(0, 39) == 0);
      model_step(r_ld, r_lv, r_st, r_pa, r_sp);
      step(r_ld, 4'(r_lv), r_st, r_pa, r_sp);
      chk("rand_cnt", int'(counter), m_cnt);
      chk("rand_busy", int'(busy), int'(m_active));
      chk("rand_done", int'(done), int'(m_done));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
